psum_accum_pipe: RTL and testbench

Parametrised, two-stage pipelined successor to the single-cycle PE partial-sum adder in the CNN accelerator datapath. Sums N_IN signed products, optionally adds incoming partial sum and bias, then optionally applies ReLU and saturation. Valid/ready handshakes on both sides allow the PE array to be back-pressured by the psum buffer writer. Sits between the multiplier outputs of a PE column and the psum SRAM write port.

---
 rtl/psum_accum_pipe_pkg.sv | 23 ++
 rtl/psum_accum_pipe_adder_tree.sv | 28 ++
 rtl/psum_accum_pipe.sv | 119 +++++++++++
 tb/tb_psum_accum_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_accum_pipe_pkg.sv
// Shared definitions for the PE-column partial-sum accumulator:
// mode encoding and the ceil-log2 helper used to size the internal sum.
package psum_accum_pipe_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_SUM  = 2'd0,
        MODE_PSUM = 2'd1,
        MODE_BIAS = 2'd2,
        MODE_RELU = 2'd3
    } mode_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_accum_pipe_adder_tree.sv
// Combinational signed reduction of N_IN packed product lanes into one
// IW-bit sum; every lane is sign-extended first so the sum cannot overflow.
module adder_tree
    import psum_accum_pipe_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int DATA_W = 32,
    parameter int IW     = 36
) (
    input  logic        [N_IN*DATA_W-1:0] data_in,
    output logic signed [IW-1:0]          sum
);

    logic signed [DATA_W-1:0] lane;
    logic signed [IW-1:0]     acc;

    always_comb begin
        acc  = '0;
        lane = '0;
        for (int i = 0; i < N_IN; i++) begin
            lane = data_in[i*DATA_W +: DATA_W];
            acc  = acc + {{(IW-DATA_W){lane[DATA_W-1]}}, lane};
        end
    end

    assign sum = acc;

endmodule

// File: rtl/psum_accum_pipe.sv
// Two-stage elastic partial-sum accumulator: S1 reduces products and selects
// psum/bias by mode, S2 adds, applies ReLU then saturation/wrap, and holds the result.
module psum_accum_pipe
    import psum_accum_pipe_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int DATA_W = 32,
    parameter int BIAS_W = 16,
    parameter int OUT_W  = 32,
    parameter int SAT    = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_IN*DATA_W-1:0]     data_in,
    input  logic signed [DATA_W-1:0]   psum,
    input  logic signed [BIAS_W-1:0]   bias,
    input  logic [MODE_W-1:0]          mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUT_W-1:0]    result,
    output logic                       sat_flag
);

    localparam int IW = DATA_W + clog2(N_IN + 2) + 1;
    // Comparison width wide enough to hold both the sum and the OUT_W limits
    localparam int CW = ((IW > OUT_W) ? IW : OUT_W) + 1;

    function automatic logic signed [IW-1:0] relu(input logic signed [IW-1:0] v,
                                                  input logic en);
        return (en && v[IW-1]) ? '0 : v;
    endfunction

    // Returns {clipped, value}; in wrap mode the value is simply truncated.
    function automatic logic [OUT_W:0] saturate(input logic signed [IW-1:0] v);
        logic signed [CW-1:0] ext;
        logic signed [CW-1:0] max_c;
        logic signed [CW-1:0] min_c;
        ext   = {{(CW-IW){v[IW-1]}}, v};
        max_c = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        min_c = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
        if (SAT == 0)         return {1'b0, ext[OUT_W-1:0]};
        else if (ext > max_c) return {1'b1, max_c[OUT_W-1:0]};
        else if (ext < min_c) return {1'b1, min_c[OUT_W-1:0]};
        else                  return {1'b0, ext[OUT_W-1:0]};
    endfunction

    logic                 vld_p1, vld_p2;
    logic                 s2_adv, in_fire, adv_p1;
    logic signed [IW-1:0] tree_sum;
    logic signed [IW-1:0] tree_sum_p1, psum_x_p1, bias_x_p1;
    logic                 relu_en_p1;
    logic signed [IW-1:0] total, total_relu;
    logic [OUT_W:0]       sat_res;
    logic signed [OUT_W-1:0] result_p2;
    logic                 sat_p2;

    assign s2_adv   = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || s2_adv;
    assign in_fire  = in_valid && in_ready;
    assign adv_p1   = vld_p1 && s2_adv;

    adder_tree #(
        .N_IN   (N_IN),
        .DATA_W (DATA_W),
        .IW     (IW)
    ) u_adder_tree (
        .data_in (data_in),
        .sum     (tree_sum)
    );

    // ---- Stage 1: product reduction and operand selection ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            tree_sum_p1 <= '0;
            psum_x_p1   <= '0;
            bias_x_p1   <= '0;
            relu_en_p1  <= 1'b0;
        end else begin
            vld_p1 <= in_fire || (vld_p1 && !s2_adv);
            if (in_fire) begin
                tree_sum_p1 <= tree_sum;
                psum_x_p1   <= (mode >= MODE_PSUM)
                               ? {{(IW-DATA_W){psum[DATA_W-1]}}, psum} : '0;
                bias_x_p1   <= (mode >= MODE_BIAS)
                               ? {{(IW-BIAS_W){bias[BIAS_W-1]}}, bias} : '0;
                relu_en_p1  <= (mode == MODE_RELU);
            end
        end
    end

    always_comb begin
        total      = tree_sum_p1 + psum_x_p1 + bias_x_p1;
        total_relu = relu(total, relu_en_p1);
        sat_res    = saturate(total_relu);
    end

    // ---- Stage 2: add, ReLU, saturate, output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            sat_p2    <= 1'b0;
        end else begin
            vld_p2 <= adv_p1 || (vld_p2 && !out_ready);
            if (adv_p1) begin
                result_p2 <= sat_res[OUT_W-1:0];
                sat_p2    <= sat_res[OUT_W];
            end
        end
    end

    assign out_valid = vld_p2;
    assign result    = result_p2;
    assign sat_flag  = sat_p2;

endmodule

// File: tb/tb_psum_accum_pipe.sv
// Randomised and directed bench for psum_accum_pipe; a saturating and a
// wrapping instance share stimulus and are scored against an integer model.
`timescale 1ns/1ps
module tb_psum_accum_pipe;

    localparam int N_IN   = 3;
    localparam int DATA_W = 32;
    localparam int BIAS_W = 16;
    localparam int OUT_W  = 32;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   out_ready = 1'b1;
    logic [N_IN*DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0]      psum = '0;
    logic [BIAS_W-1:0]      bias = '0;
    logic [1:0]             mode = '0;
    logic                   in_ready, out_valid, sat_flag;
    logic [OUT_W-1:0]       result;
    logic                   in_ready_w, out_valid_w, sat_flag_w;
    logic [OUT_W-1:0]       result_w;

    typedef struct {
        longint r_sat;
        longint f_sat;
        longint r_wrap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   rnd_done;

    psum_accum_pipe #(.N_IN(N_IN), .DATA_W(DATA_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W), .SAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .psum(psum), .bias(bias), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .sat_flag(sat_flag)
    );

    psum_accum_pipe #(.N_IN(N_IN), .DATA_W(DATA_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W), .SAT(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .data_in(data_in), .psum(psum), .bias(bias), .mode(mode),
        .out_valid(out_valid_w), .out_ready(out_ready), .result(result_w), .sat_flag(sat_flag_w)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Behavioural reference: plain integer arithmetic on the whole beat.
    function automatic exp_t model(input logic [N_IN*DATA_W-1:0] d, input logic [31:0] ps,
                                   input logic [15:0] bs, input logic [1:0] md);
        longint t;
        exp_t   e;
        t = 0;
        for (int i = 0; i < N_IN; i++) t += longint'($signed(d[i*DATA_W +: DATA_W]));
        if (md >= 2'd1) t += longint'($signed(ps));
        if (md >= 2'd2) t += longint'($signed(bs));
        if (md == 2'd3 && t < 0) t = 0;
        e.r_wrap = longint'(int'(t));
        if (t > MAXV)      begin e.r_sat = MAXV; e.f_sat = 1; end
        else if (t < MINV) begin e.r_sat = MINV; e.f_sat = 1; end
        else               begin e.r_sat = t;    e.f_sat = 0; end
        return e;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 3))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'($urandom_range(0, 200)) - 32'd100;
            default: return $urandom;
        endcase
    endfunction

    task automatic monitor();
        bit          prev_stall = 0;
        logic [31:0] prev_res = '0;
        logic        prev_flag = 0;
        exp_t        e;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                sb.delete();
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_result", result, prev_res);
                    chk("hold_flag", sat_flag, prev_flag);
                end
                if (out_valid) begin
                    if (sb.size() == 0) chk("spurious_out", 1, 0);
                    else if (out_ready) begin
                        e = sb.pop_front();
                        chk("result", $signed(result), e.r_sat);
                        chk("sat_flag", sat_flag, e.f_sat);
                        chk("wrap_valid", out_valid_w, 1);
                        chk("wrap_result", $signed(result_w), e.r_wrap);
                        chk("wrap_flag", sat_flag_w, 0);
                    end
                end
                if (in_valid && in_ready) sb.push_back(model(data_in, psum, bias, mode));
                prev_stall = out_valid && !out_ready;
                prev_res   = result;
                prev_flag  = sat_flag;
            end
        end
    endtask

    // Presents a beat and returns just after the edge that accepted it.
    task automatic send(input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] l2,
                        input logic [31:0] ps, input logic [15:0] bs, input logic [1:0] md);
        bit fired;
        fired    = 0;
        data_in  = {l2, l1, l0};
        psum     = ps;
        bias     = bs;
        mode     = md;
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin fired = 1; break; end
        end
        if (!fired) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [31:0] l0, input logic [31:0] l1,
                           input logic [31:0] l2, input logic [31:0] ps, input logic [15:0] bs,
                           input logic [1:0] md, input longint exp_r, input longint exp_f,
                           input longint exp_w);
        send(l0, l1, l2, ps, bs, md);
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_early"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_result"}, $signed(result), exp_r);
        chk({tag, "_flag"}, sat_flag, exp_f);
        chk({tag, "_wrap"}, $signed(result_w), exp_w);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        longint t0, t1;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_sat_flag", sat_flag, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);

        run_one("mode0", 32'd5, -32'sd2, 32'd10, 32'd100, -16'sd7, 2'd0, 13, 0, 13);
        run_one("mode1", 32'd5, -32'sd2, 32'd10, 32'd100, -16'sd7, 2'd1, 113, 0, 113);
        run_one("mode2", 32'd5, -32'sd2, 32'd10, 32'd100, -16'sd7, 2'd2, 106, 0, 106);
        run_one("mode3", 32'd5, -32'sd2, 32'd10, -32'sd200, -16'sd7, 2'd3, 0, 0, 0);
        run_one("sat_hi", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd1, 32'd12345, 16'd99, 2'd0,
                MAXV, 1, -1);
        run_one("sat_lo", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 16'd0, 2'd0,
                MINV, 1, MAXV);
        run_one("wrap", 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 16'd0, 2'd0, MAXV, 1, MINV);
        run_one("relu_big_neg", 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 16'd0, 2'd3, 0, 0, 0);

        // Back-pressure: out_ready low for cycles 3..7 of a 10-beat stream
        fork
            begin
                for (int n = 1; n <= 10; n++) send(32'(n), 0, 0, 0, 0, 2'd0);
                in_valid = 1'b0;
            end
            begin
                for (int c = 1; c <= 8; c++) begin
                    @(posedge clk);
                    #1;
                    if (c == 3) out_ready = 1'b0;
                    if (c == 8) out_ready = 1'b1;
                    if (c == 6) begin
                        @(negedge clk);
                        chk("bp_in_ready", in_ready, 0);
                        chk("bp_out_valid", out_valid, 1);
                        chk("bp_buffered", sb.size(), 2);
                    end
                end
            end
        join
        drain("bp_drain");

        t0 = $time;
        for (int n = 1; n <= 10; n++) send(32'(n + 20), 0, 0, 0, 0, 2'd0);
        t1 = $time;
        in_valid = 1'b0;
        chk("throughput_cycles", (t1 - t0) / 10, 10);
        drain("tp_drain");

        rnd_done = 0;
        fork
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send(rnd_word(), rnd_word(), rnd_word(), rnd_word(),
                         16'($urandom), 2'($urandom));
                end
                in_valid = 1'b0;
                rnd_done = 1;
            end
        join
        out_ready = 1'b1;
        drain("rnd_drain");

        // Mid-stream reset with two beats buffered
        out_ready = 1'b0;
        send(32'd77, 0, 0, 0, 0, 2'd0);
        send(32'd88, 0, 0, 0, 0, 2'd0);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_sat_flag", sat_flag, 0);
        chk("mid_rst_wrap_valid", out_valid_w, 0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mid_rst_flushed", out_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
